// File: rtl/demux12_pkg.sv
// demux12_pkg: shared constants and types for the 1-to-2 buffered demux.
// The optional DEMUX12_SKID_EN macro, when defined, deepens every output
// buffer from one entry to two (see demux12_slot).
package demux12_pkg;

  // Default data word width
  localparam int DEMUX12_WIDTH = 32;

  // Data word at the default width
  typedef logic [DEMUX12_WIDTH-1:0] data_t;

  // Select encoding: which in_sel value names which output
  localparam logic SEL_OUT0 = 1'b0;
  localparam logic SEL_OUT1 = 1'b1;

  // True when a select value routes to output 0 under a given mapping
  function automatic logic routes_to_out0(input logic sel, input logic sel_first);
    return (sel == sel_first);
  endfunction

endpackage

// File: rtl/demux12_slot.sv
// demux12_slot: per-output buffer with a valid/ready drain side.
// Default build: single entry. With DEMUX12_SKID_EN defined: 2-entry FIFO
// (head + tail), so one consumer stall does not throttle the producer.
// out_data is always the head register: it is held while stalled and keeps
// the last presented word after the buffer drains empty.
module demux12_slot
  import demux12_pkg::*;
#(
  parameter int WIDTH = DEMUX12_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic             can_accept,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic             head_valid_r;
  logic [WIDTH-1:0] head_data_r;
  logic             head_valid_s;
  logic [WIDTH-1:0] head_data_s;
  logic             drain_s;

  assign drain_s   = head_valid_r & pop_ready;
  assign out_valid = head_valid_r;
  assign out_data  = head_data_r;

`ifdef DEMUX12_SKID_EN

  logic             tail_valid_r;
  logic [WIDTH-1:0] tail_data_r;
  logic             tail_valid_s;
  logic [WIDTH-1:0] tail_data_s;

  // Room exists when the tail is free or the head leaves this cycle
  always_comb begin
    can_accept = (~tail_valid_r) | drain_s;
  end

  // Next state of the two-entry FIFO for each drain/push combination
  always_comb begin
    head_valid_s = head_valid_r;
    head_data_s  = head_data_r;
    tail_valid_s = tail_valid_r;
    tail_data_s  = tail_data_r;
    case ({drain_s, push})
      2'b00: begin
        head_valid_s = head_valid_r;
      end
      2'b01: begin
        if (!head_valid_r) begin
          head_valid_s = 1'b1;
          head_data_s  = push_data;
        end else begin
          tail_valid_s = 1'b1;
          tail_data_s  = push_data;
        end
      end
      2'b10: begin
        if (tail_valid_r) begin
          head_data_s  = tail_data_r;
          tail_valid_s = 1'b0;
        end else begin
          head_valid_s = 1'b0;
        end
      end
      2'b11: begin
        // Occupancy unchanged: shift tail forward and refill, or replace head
        if (tail_valid_r) begin
          head_data_s = tail_data_r;
          tail_data_s = push_data;
        end else begin
          head_data_s = push_data;
        end
      end
      default: begin
        head_valid_s = head_valid_r;
      end
    endcase
  end

  // FIFO registers; reset empties both entries and zeroes the data
  always_ff @(posedge clk) begin
    if (rst) begin
      head_valid_r <= 1'b0;
      head_data_r  <= {WIDTH{1'b0}};
      tail_valid_r <= 1'b0;
      tail_data_r  <= {WIDTH{1'b0}};
    end else begin
      head_valid_r <= head_valid_s;
      head_data_r  <= head_data_s;
      tail_valid_r <= tail_valid_s;
      tail_data_r  <= tail_data_s;
    end
  end

`else

  // Single entry: room when empty or when the held word leaves this cycle
  always_comb begin
    can_accept = (~head_valid_r) | pop_ready;
  end

  // Next state of the single entry; a push wins over a drain (both happen)
  always_comb begin
    head_valid_s = head_valid_r;
    head_data_s  = head_data_r;
    if (push) begin
      head_valid_s = 1'b1;
      head_data_s  = push_data;
    end else if (drain_s) begin
      head_valid_s = 1'b0;
    end else begin
      head_valid_s = head_valid_r;
    end
  end

  // Entry register; reset empties it and zeroes the data
  always_ff @(posedge clk) begin
    if (rst) begin
      head_valid_r <= 1'b0;
      head_data_r  <= {WIDTH{1'b0}};
    end else begin
      head_valid_r <= head_valid_s;
      head_data_r  <= head_data_s;
    end
  end

`endif

endmodule

// File: rtl/demux12_pipe.sv
// demux12_pipe: routes a valid/ready word stream to one of two buffered
// outputs by in_sel. Each output owns an independent demux12_slot, so a
// stalled consumer only blocks words addressed to it. Optional macro:
// DEMUX12_SKID_EN (2-entry buffers instead of 1-entry).
module demux12_pipe
  import demux12_pkg::*;
#(
  parameter int   WIDTH     = DEMUX12_WIDTH,
  parameter logic SEL_FIRST = SEL_OUT0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data
);

  logic to0_s;
  logic accept0_s;
  logic accept1_s;
  logic push0_s;
  logic push1_s;

  // Destination decode and readiness of the addressed buffer only;
  // in_valid deliberately plays no part in in_ready
  always_comb begin
    to0_s = routes_to_out0(in_sel, SEL_FIRST);
    if (rst) begin
      in_ready = 1'b0;
    end else if (to0_s) begin
      in_ready = accept0_s;
    end else begin
      in_ready = accept1_s;
    end
  end

  // A handshake writes only the selected buffer
  always_comb begin
    push0_s = in_valid & in_ready & to0_s;
    push1_s = in_valid & in_ready & (~to0_s);
  end

  demux12_slot #(.WIDTH(WIDTH)) u_slot0 (
    .clk        (clk),
    .rst        (rst),
    .push       (push0_s),
    .push_data  (in_data),
    .pop_ready  (out0_ready),
    .can_accept (accept0_s),
    .out_valid  (out0_valid),
    .out_data   (out0_data)
  );

  demux12_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clk        (clk),
    .rst        (rst),
    .push       (push1_s),
    .push_data  (in_data),
    .pop_ready  (out1_ready),
    .can_accept (accept1_s),
    .out_valid  (out1_valid),
    .out_data   (out1_data)
  );

endmodule

// File: tb/tb_demux12_pipe.sv
// tb_demux12_pipe: directed steps plus a random phase; a queue per output
// holds the words expected to be buffered, and each cycle the bench checks
// in_ready, valids and data against that model before the clock edge.
module tb_demux12_pipe;
  import demux12_pkg::*;

`ifdef DEMUX12_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic  clk;
  logic  rst;
  logic  in_valid;
  logic  in_ready;
  data_t in_data;
  logic  in_sel;
  logic  out0_valid;
  logic  out0_ready;
  data_t out0_data;
  logic  out1_valid;
  logic  out1_ready;
  data_t out1_data;

  demux12_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  data_t q0[$];
  data_t q1[$];
  data_t last0 = 32'h0;
  data_t last1 = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs are already applied (#1 after an edge); check, update model, advance
  task automatic step();
    logic  exp_rdy;
    logic  room0;
    logic  room1;
    data_t exp_d0;
    data_t exp_d1;
    #2;
    room0   = (q0.size() < DEPTH) || ((q0.size() > 0) && out0_ready);
    room1   = (q1.size() < DEPTH) || ((q1.size() > 0) && out1_ready);
    exp_rdy = rst ? 1'b0 : ((in_sel == 1'b0) ? room0 : room1);
    exp_d0  = (q0.size() > 0) ? q0[0] : last0;
    exp_d1  = (q1.size() > 0) ? q1[0] : last1;
    check("in_ready", {31'h0, in_ready}, {31'h0, exp_rdy});
    check("out0_valid", {31'h0, out0_valid}, {31'h0, (q0.size() > 0)});
    check("out1_valid", {31'h0, out1_valid}, {31'h0, (q1.size() > 0)});
    check("out0_data", out0_data, exp_d0);
    check("out1_data", out1_data, exp_d1);
    if (rst) begin
      q0.delete();
      q1.delete();
      last0 = 32'h0;
      last1 = 32'h0;
    end else begin
      if ((q0.size() > 0) && out0_ready) last0 = q0.pop_front();
      if ((q1.size() > 0) && out1_ready) last1 = q1.pop_front();
      if (in_valid && exp_rdy) begin
        if (in_sel == 1'b0) q0.push_back(in_data);
        else q1.push_back(in_data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [31:0] d,
                       input logic r0, input logic r1);
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 1'b0, 32'h1234_5678, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    // Reset held: in_ready low, outputs cleared, offered word dropped
    step();
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    step();

    // Single word to output 0, out1 stays idle
    drive(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    step();
    step();

    // Back-to-back stream to output 1
    drive(1'b1, 1'b1, 32'h11, 1'b0, 1'b1);
    step();
    drive(1'b1, 1'b1, 32'h22, 1'b0, 1'b1);
    step();
    drive(1'b1, 1'b1, 32'h33, 1'b0, 1'b1);
    step();
    drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
    step();
    step();

    // Stall output 0; the other output keeps flowing
    drive(1'b1, 1'b0, 32'hA, 1'b0, 1'b1);
    step();
    drive(1'b1, 1'b0, 32'hB, 1'b0, 1'b1);
    step();
    drive(1'b1, 1'b1, 32'hC, 1'b0, 1'b1);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    step();

    // Output 0 full: drain and accept in the same cycle
    drive(1'b1, 1'b0, 32'h55, 1'b1, 1'b1);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    step();
    step();
    step();

    // Output 1 stalled for 5 cycles: data must hold
    drive(1'b1, 1'b1, 32'h77, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b0, 32'h66, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step();

    // Reset mid-operation with a word offered
    rst = 1'b1;
    drive(1'b1, 1'b0, 32'h99, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    step();

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, $urandom,
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0));
      step();
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    step();
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux12_pipe.md
DEMUX12_PIPE -- requirements
Module: demux12_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width.
REQ-002 SHALL have parameter SEL_FIRST, default 0, the in_sel value that routes to output 0; the other value routes to output 1.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, producer offers a word.
REQ-006 SHALL have port in_ready, output, 1, block accepts the offered word this cycle.
REQ-007 SHALL have port in_data, input, WIDTH, offered word.
REQ-008 SHALL have port in_sel, input, 1, destination select.
REQ-009 SHALL have ports out0_valid and out1_valid, output, 1 each, word available on that output.
REQ-010 SHALL have ports out0_ready and out1_ready, input, 1 each, consumer takes the word.
REQ-011 SHALL have ports out0_data and out1_data, output, WIDTH each, buffered word.

Function
REQ-012 SHALL accept a word on any cycle where in_valid and in_ready are both 1, storing it in the buffer of the selected output.
REQ-013 SHALL drive in_ready combinationally from in_sel and the selected buffer's state only: 1 when that buffer has a free entry or its head is being drained this cycle (valid and ready both 1).
REQ-014 SHALL NOT make in_ready depend on in_valid.
REQ-015 SHALL present a word accepted at edge N on its output with valid=1 from cycle N+1; minimum latency is 1 cycle, with no combinational in-to-out path.
REQ-016 SHALL hold outX_data and outX_valid stable while outX_valid=1 and outX_ready=0.
REQ-017 SHALL preserve order per output; no ordering guarantee across outputs.
REQ-018 SHALL leave the unselected output's buffer and signals unaffected by an accept.
REQ-019 SHALL handle a simultaneous drain and accept on the same output as both occurring, with occupancy unchanged.
REQ-020 SHALL NOT let a stall on one output block the other: in_ready for in_sel pointing to a non-full buffer is 1.
REQ-021 SHALL ignore in_data and in_sel when in_valid=0.
REQ-022 SHALL keep outX_data equal to the last presented word, not zeroed, when the buffer drains empty.

Reset
REQ-023 SHALL, with rst=1 at a clock edge, set out0_valid=0, out1_valid=0, out0_data=0, out1_data=0 and empty both buffers.
REQ-024 SHALL drive in_ready=0 while rst=1.
REQ-025 SHALL discard buffered words on reset mid-operation, and SHALL NOT accept a word offered in the reset cycle.

Configuration
REQ-026 SHALL, with DEMUX12_SKID_EN defined, give each output a 2-entry FIFO buffer, allowing full input throughput while that consumer stalls one cycle.
REQ-027 SHALL, without DEMUX12_SKID_EN, give each output a single-entry buffer; back-to-back words to one output then need outX_ready=1 every cycle to sustain one word per cycle.

Structure
REQ-028 SHALL place the WIDTH default, the data word typedef and the select encoding constants in shared package demux12_pkg.
REQ-029 SHALL implement each output buffer as one instance of sub-module demux12_slot, instantiated twice; it contains the DEMUX12_SKID_EN conditional.

Verification
REQ-030 SHALL cover this case: after reset, drive in_valid=1, in_sel=0, in_data=0xDEADBEEF with out0_ready=1 -> out0_valid=1, out0_data=0xDEADBEEF one cycle later, and out1_valid stays 0.
REQ-031 SHALL cover this case: send 0x11, 0x22, 0x33 on consecutive cycles to output 1 with out1_ready=1 -> the same sequence on out1_data on consecutive cycles, with in_ready constantly 1.
REQ-032 SHALL cover this case: hold out0_ready=0, send 0xA to output 0, then 0xB to output 0, then 0xC to output 1 -> in_ready=0 for 0xB without skid (1 with skid), in_ready=1 for 0xC, and 0xC appears on out1.
REQ-033 SHALL cover this case: with output 0 full and out0_ready=1, offer 0x55 to output 0 in the same cycle -> accepted, the old head leaves, 0x55 is the next word, and occupancy is unchanged.
REQ-034 SHALL cover this case: buffer words in both outputs, then assert rst for one cycle while in_valid=1 -> both valids are 0 next cycle, data is 0, and the offered word is lost.
REQ-035 SHALL cover this case: hold out1_ready=0 for 5 cycles with out1_valid=1 -> out1_data is unchanged every cycle.
